// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
//   Responder side of a 4x4 matrix keypad scan interface. It watches the
//   scanner's column drive and returns the row lines a real keypad would give
//   for one commanded key press, optionally including contact bounce on make
//   and on break.
//
//   Optional feature macro: KEYPAD_EMU_BOUNCE_EN
//     defined   : MAKE_BOUNCE / BREAK_BOUNCE phases driven by an 8-bit LFSR
//     undefined : clean contact, IDLE -> HELD -> IDLE
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   col[3:0]     column drive from scanner (active-high, any pattern)
//   key_code     [3:2] column index, [1:0] row index of the key to press
//   hold_cycles  cycles the contact is solidly closed (0 behaves as 1)
//   press_valid  press request valid
//   press_ready  high while a request can be accepted (IDLE only)
//   row[3:0]     row lines to scanner, active-high, registered
//   contact      internal contact state (debug)
//   release_done one-cycle pulse in the first IDLE cycle after a press
// ---------------------------------------------------------------------------
module keypad_emulator #(
    parameter int         BOUNCE_CYCLES = 16,
    parameter int         HOLD_W        = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        col,
    input  logic [3:0]        key_code,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              press_valid,
    output logic              press_ready,
    output logic [3:0]        row,
    output logic              contact,
    output logic              release_done
);

`ifdef KEYPAD_EMU_BOUNCE_EN
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        MAKE_BOUNCE  = 2'd1,
        HELD         = 2'd2,
        BREAK_BOUNCE = 2'd3
    } state_t;

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam int BCNT_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BOUNCE_CYCLES - 1);

    logic [7:0]        lfsr_r;
    logic [7:0]        lfsr_s;
    logic [BCNT_W-1:0] bcnt_r;
    logic [BCNT_W-1:0] bcnt_s;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4; newest bit enters at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        lfsr_step = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;
`endif

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        key_r;
    logic [3:0]        key_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_s;
    logic              contact_r;
    logic              contact_s;
    logic              ready_r;
    logic              done_r;
    logic              done_s;
    logic [3:0]        row_r;

    // Only the commanded column is looked at; at most one row bit results.
    function automatic logic [3:0] row_decode(input logic c, input logic [3:0] cl,
                                              input logic [3:0] k);
        if (c && cl[k[3:2]]) begin
            row_decode = 4'b0001 << k[1:0];
        end else begin
            row_decode = 4'b0000;
        end
    endfunction

    // Next-state, latched request and next contact value.
    always_comb begin
        state_s = state_r;
        key_s   = key_r;
        hold_s  = hold_r;
`ifdef KEYPAD_EMU_BOUNCE_EN
        bcnt_s  = bcnt_r;
        if (state_r == MAKE_BOUNCE || state_r == BREAK_BOUNCE) begin
            lfsr_s = lfsr_step(lfsr_r);
        end else begin
            lfsr_s = lfsr_r;
        end
`endif
        case (state_r)
            IDLE: begin
                if (press_valid && ready_r) begin
                    key_s  = key_code;
                    hold_s = (hold_cycles == {HOLD_W{1'b0}}) ? HOLD_W'(1) : hold_cycles;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_s = MAKE_BOUNCE;
`else
                    state_s = HELD;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            MAKE_BOUNCE: begin
                if (bcnt_r == BCNT_LAST) begin
                    bcnt_s  = {BCNT_W{1'b0}};
                    state_s = HELD;
                end else begin
                    bcnt_s  = bcnt_r + BCNT_W'(1);
                end
            end
            BREAK_BOUNCE: begin
                if (bcnt_r == BCNT_LAST) begin
                    bcnt_s  = {BCNT_W{1'b0}};
                    state_s = IDLE;
                end else begin
                    bcnt_s  = bcnt_r + BCNT_W'(1);
                end
            end
`endif
            HELD: begin
                // Down-counter from the latched length keeps all-ones exact.
                if (hold_r <= HOLD_W'(1)) begin
                    hold_s = {HOLD_W{1'b0}};
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_s = BREAK_BOUNCE;
`else
                    state_s = IDLE;
`endif
                end else begin
                    hold_s = hold_r - HOLD_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // contact is registered, so it is decoded from the state being entered.
        case (state_s)
            HELD: contact_s = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            MAKE_BOUNCE, BREAK_BOUNCE: contact_s = lfsr_s[0];
`endif
            default: contact_s = 1'b0;
        endcase

        done_s = (state_r != IDLE) && (state_s == IDLE);
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            key_r     <= 4'b0000;
            hold_r    <= {HOLD_W{1'b0}};
            contact_r <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            row_r     <= 4'b0000;
        end else begin
            state_r   <= state_s;
            key_r     <= key_s;
            hold_r    <= hold_s;
            contact_r <= contact_s;
            ready_r   <= (state_s == IDLE);
            done_r    <= done_s;
            row_r     <= row_decode(contact_r, col, key_r);
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Bounce pattern generator and bounce phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= SEED;
            bcnt_r <= {BCNT_W{1'b0}};
        end else begin
            lfsr_r <= lfsr_s;
            bcnt_r <= bcnt_s;
        end
    end
`endif

    assign press_ready  = ready_r;
    assign row          = row_r;
    assign contact      = contact_r;
    assign release_done = done_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_emulator
//   Self-checking bench for keypad_emulator. A reference model holds the
//   future contact pattern of the current press as a queue of bits; row,
//   press_ready and release_done follow from that queue. Works with and
//   without KEYPAD_EMU_BOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_keypad_emulator;
    localparam int HOLD_W = 16;
    localparam int B      = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        col;
    logic [3:0]        key_code;
    logic [HOLD_W-1:0] hold_cycles;
    logic              press_valid;
    logic              press_ready;
    logic [3:0]        row;
    logic              contact;
    logic              release_done;

    always #5 clk = ~clk;

    keypad_emulator #(
        .BOUNCE_CYCLES(B),
        .HOLD_W       (HOLD_W),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col         (col),
        .key_code    (key_code),
        .hold_cycles (hold_cycles),
        .press_valid (press_valid),
        .press_ready (press_ready),
        .row         (row),
        .contact     (contact),
        .release_done(release_done)
    );

    int checks    = 0;
    int failures  = 0;
    int row_hits  = 0;
    int done_hits = 0;

    // reference model state
    bit         q[$];
    logic [3:0] exp_row;
    logic [3:0] key_m;
    logic       exp_contact;
    logic       exp_ready;
    logic       exp_done;
    logic [7:0] lfsr_m;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_row     = 4'b0000;
        exp_contact = 1'b0;
        exp_ready   = 1'b1;
        exp_done    = 1'b0;
        key_m       = 4'b0000;
        lfsr_m      = 8'hA5;
    endtask

    // Advance the model across one rising edge using the driven inputs.
    task automatic model_edge();
        logic [3:0] nrow;
        int h;
        nrow = (exp_contact && col[key_m[3:2]]) ? (4'b0001 << key_m[1:0]) : 4'b0000;
        if (exp_ready && press_valid) begin
            key_m = key_code;
            h = (hold_cycles == 16'd0) ? 1 : int'(hold_cycles);
`ifdef KEYPAD_EMU_BOUNCE_EN
            for (int i = 0; i < B; i++) begin
                q.push_back(lfsr_m[0]);
                lfsr_m = lfsr_next(lfsr_m);
            end
`endif
            for (int i = 0; i < h; i++) q.push_back(1'b1);
`ifdef KEYPAD_EMU_BOUNCE_EN
            for (int i = 0; i < B; i++) begin
                q.push_back(lfsr_m[0]);
                lfsr_m = lfsr_next(lfsr_m);
            end
`endif
        end
        if (q.size() > 0) begin
            exp_done    = 1'b0;
            exp_contact = q.pop_front();
            exp_ready   = 1'b0;
        end else begin
            exp_done    = !exp_ready;
            exp_contact = 1'b0;
            exp_ready   = 1'b1;
        end
        exp_row = nrow;
    endtask

    task automatic check_all();
        chk("row", row, exp_row);
        chk("contact", {3'b000, contact}, {3'b000, exp_contact});
        chk("press_ready", {3'b000, press_ready}, {3'b000, exp_ready});
        chk("release_done", {3'b000, release_done}, {3'b000, exp_done});
        if (row !== 4'b0000) row_hits++;
        if (release_done === 1'b1) done_hits++;
    endtask

    // Drive inputs (at negedge), take one clock, check at the next negedge.
    task automatic step(input logic pv, input logic [3:0] kc,
                        input logic [HOLD_W-1:0] hc, input logic [3:0] cl);
        press_valid = pv;
        key_code    = kc;
        hold_cycles = hc;
        col         = cl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drain(input logic [3:0] cl, input int maxc);
        int n;
        n = 0;
        while (!(exp_ready && !exp_done) && n < maxc) begin
            step(1'b0, 4'b0000, 16'd0, cl);
            n++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        col         = 4'b1111;
        press_valid = 1'b0;
        key_code    = 4'b0000;
        hold_cycles = 16'd0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;
        repeat (3) step(1'b0, 4'b0000, 16'd0, 4'b1111);

        // clean press on c=1 r=2, matching column
        row_hits = 0; done_hits = 0;
        step(1'b1, 4'b0110, 16'd5, 4'b0010);
        drain(4'b0010, 200);
        step(1'b0, 4'b0000, 16'd0, 4'b0010);
`ifndef KEYPAD_EMU_BOUNCE_EN
        chk("clean_row_cycles", 4'(row_hits), 4'd5);
`endif
        chk("clean_done_pulses", 4'(done_hits), 4'd1);

        // column mismatch: row never asserts, release_done still pulses
        row_hits = 0; done_hits = 0;
        step(1'b1, 4'b0110, 16'd5, 4'b0001);
        drain(4'b0001, 200);
        step(1'b0, 4'b0000, 16'd0, 4'b0001);
        chk("mismatch_row_cycles", 4'(row_hits), 4'd0);
        chk("mismatch_done_pulses", 4'(done_hits), 4'd1);

        // handshake: requests while busy are ignored, next IDLE request taken
        step(1'b1, 4'b0110, 16'd4, 4'b0010);
        repeat (3) step(1'b1, 4'b1111, 16'd2, 4'b1010);
        drain(4'b1010, 200);
        step(1'b1, 4'b1101, 16'd0, 4'b1000);
        drain(4'b1000, 200);
        step(1'b0, 4'b0000, 16'd0, 4'b0000);

        // asynchronous reset in the third hold cycle
        step(1'b1, 4'b0000, 16'd10, 4'b0001);
`ifdef KEYPAD_EMU_BOUNCE_EN
        repeat (B) step(1'b0, 4'b0000, 16'd0, 4'b0001);
`endif
        repeat (2) step(1'b0, 4'b0000, 16'd0, 4'b0001);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_row", row, 4'b0000);
        chk("async_rst_ready", {3'b000, press_ready}, 4'b0001);
        chk("async_rst_contact", {3'b000, contact}, 4'b0000);
        chk("async_rst_done", {3'b000, release_done}, 4'b0000);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        done_hits = 0;
        repeat (4) step(1'b0, 4'b0000, 16'd0, 4'b0001);
        chk("async_rst_no_done", 4'(done_hits), 4'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 12)), 4'($urandom_range(0, 15)));
        end
        drain(4'b0000, 200);
        step(1'b0, 4'b0000, 16'd0, 4'b0000);

        // maximum hold length
        row_hits = 0; done_hits = 0;
        step(1'b1, 4'b1011, 16'hFFFF, 4'b0100);
        drain(4'b0100, 70000);
        step(1'b0, 4'b0000, 16'd0, 4'b0100);
`ifndef KEYPAD_EMU_BOUNCE_EN
        chk("max_hold_row_cycles", (row_hits == 65535) ? 4'd1 : 4'd0, 4'd1);
`endif
        chk("max_hold_done_pulses", 4'(done_hits), 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
